// File: rtl/mac_tile_simd.sv
// mac_tile_simd
// Weight-stationary systolic MAC tile with run-time SIMD activation precision.
// One tile runs one lane of bw-bit, two lanes of bw/2-bit or four lanes of
// bw/4-bit unsigned activations, each lane against its own signed bw-bit
// stationary weight. A small load FSM captures the lane weights and then
// forwards further kernel-load instructions east.
//
// Build option: define MAC_TILE_SAT_EN to clamp the partial sum to the signed
// psum_bw range; otherwise the sum wraps (two's complement).
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   in_w    in   [bw-1:0]      activation (execute) / weight (kernel load) from west
//   inst_w  in   [1:0]         bit1 execute, bit0 kernel load
//   in_n    in   [psum_bw-1:0] partial sum from north
//   mode    in   [1:0]         0: 1 lane, 1: 2 lanes, 2: 4 lanes, 3: as 0
//   reload  in   return a READY tile to IDLE for a new kernel
//   out_e   out  [bw-1:0]      registered activation to east
//   inst_e  out  [1:0]         registered instruction to east
//   out_s   out  [psum_bw-1:0] partial sum to south (comb. from registers)
module mac_tile_simd #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      in_w,
    input  logic [1:0]         inst_w,
    input  logic [psum_bw-1:0] in_n,
    input  logic [1:0]         mode,
    input  logic               reload,
    output logic [bw-1:0]      out_e,
    output logic [1:0]         inst_e,
    output logic [psum_bw-1:0] out_s
);

    localparam int SW = psum_bw + 3;   // internal sum width before reduction
    localparam int HW = bw / 2;        // lane width in 2-lane mode
    localparam int QW = bw / 4;        // lane width in 4-lane mode

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

    logic [1:0]         state_r;
    logic [1:0]         mode_r;
    logic [1:0]         cnt_r;
    logic [1:0]         inst_r;
    logic [bw-1:0]      a_r;
    logic [psum_bw-1:0] c_r;
    logic [bw-1:0]      w_r [4];

    logic [bw-1:0]        act_s [4];
    logic signed [SW-1:0] sum_s;
    logic [psum_bw-1:0]   res_s;

    // Index of the last lane for a mode (lane count minus one); 3 acts as 0.
    function automatic logic [1:0] last_lane(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'd1:    r = 2'd1;
            2'd2:    r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Control FSM, weight capture and west-to-east pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mode_r  <= 2'd0;
            cnt_r   <= 2'd0;
            inst_r  <= 2'b00;
            a_r     <= {bw{1'b0}};
            c_r     <= {psum_bw{1'b0}};
            for (int i = 0; i < 4; i++) begin
                w_r[i] <= {bw{1'b0}};
            end
        end else begin
            c_r       <= in_n;
            inst_r[1] <= inst_w[1];
            // Load instructions are consumed locally until every lane holds a weight.
            inst_r[0] <= (state_r == ST_READY) ? inst_w[0] : 1'b0;
            if (inst_w != 2'b00) begin
                a_r <= in_w;
            end
            case (state_r)
                ST_IDLE: begin
                    mode_r <= mode;
                    cnt_r  <= 2'd0;
                    if (inst_w[0]) begin
                        w_r[0] <= in_w;
                        // Lane count comes from the mode captured this same cycle,
                        // so the LOAD phase and the arithmetic agree on it.
                        if (last_lane(mode) == 2'd0) begin
                            state_r <= ST_READY;
                        end else begin
                            cnt_r   <= 2'd1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (inst_w[0]) begin
                        w_r[cnt_r] <= in_w;
                        cnt_r      <= cnt_r + 2'd1;
                        if (cnt_r == last_lane(mode_r)) begin
                            state_r <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    // A load arriving with reload is forwarded, not captured.
                    if (reload) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane split of the activation and signed multiply-accumulate.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            act_s[i] = {bw{1'b0}};
        end
        case (mode_r)
            2'd1: begin
                for (int i = 0; i < 2; i++) begin
                    act_s[i] = {{(bw-HW){1'b0}}, a_r[i*HW +: HW]};
                end
            end
            2'd2: begin
                for (int i = 0; i < 4; i++) begin
                    act_s[i] = {{(bw-QW){1'b0}}, a_r[i*QW +: QW]};
                end
            end
            default: begin
                act_s[0] = a_r;
            end
        endcase
        sum_s = {{(SW-psum_bw){c_r[psum_bw-1]}}, c_r};
        // Unused lanes have a zero activation and add nothing.
        for (int i = 0; i < 4; i++) begin
            sum_s = sum_s + ($signed({{(SW-bw){1'b0}}, act_s[i]}) *
                             $signed({{(SW-bw){w_r[i][bw-1]}}, w_r[i]}));
        end
    end

    // Reduce the wide sum to psum_bw bits.
    always_comb begin
        res_s = sum_s[psum_bw-1:0];
`ifdef MAC_TILE_SAT_EN
        if (sum_s > SAT_MAX) begin
            res_s = SAT_MAX[psum_bw-1:0];
        end else if (sum_s < SAT_MIN) begin
            res_s = SAT_MIN[psum_bw-1:0];
        end else begin
            res_s = sum_s[psum_bw-1:0];
        end
`else
        res_s = sum_s[psum_bw-1:0];
`endif
    end

    assign out_e  = a_r;
    assign inst_e = inst_r;
    assign out_s  = res_s;

endmodule

// File: doc/mac_tile_simd.md
# mac_tile_simd

Parametrised successor of the weight-stationary systolic MAC tile. One tile supports three activation precisions at run time: one lane of `bw`-bit, two lanes of `bw/2`-bit, or four lanes of `bw/4`-bit unsigned activations. Each lane has its own signed `bw`-bit stationary weight. A small load state machine captures the lane weights, then forwards kernel-load instructions east. The tile drops into the same array grid (west→east activations/instructions, north→south partial sums) as the existing tile.

## Interface
- `bw`, 4, activation/weight width; must be a multiple of 4.
- `psum_bw`, 16, partial-sum width.
- `clk`  input  1  clock, all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_w`  input  bw  activation (execute) or weight (kernel load) from west.
- `inst_w`  input  2  bit1 execute, bit0 kernel load.
- `in_n`  input  psum_bw  partial sum from north.
- `mode`  input  2  0: 1×bw lane, 1: 2×(bw/2) lanes, 2: 4×(bw/4) lanes, 3: reserved, behaves as 0.
- `reload`  input  1  return a READY tile to IDLE for a new kernel.
- `out_e`  output  bw  registered activation to east.
- `inst_e`  output  2  registered instruction to east.
- `out_s`  output  psum_bw  partial sum to south, combinational from registered state.

## Operation
- Lane count L = 1/2/4 for `mode_q` 0/1/2. Lane i activation = `a_q[(i+1)*bw/L-1 : i*bw/L]`, zero-extended unsigned. Weight `w_q[i]` is signed `bw`-bit.
- FSM states: IDLE, LOAD, READY.
  - IDLE: `mode_q <= mode` every cycle; `cnt <= 0`. When `inst_w[0]=1`: write `w_q[0] <= in_w`. If L=1, go to READY; otherwise set `cnt <= 1` and go to LOAD.
  - LOAD: `mode_q` frozen. When `inst_w[0]=1`: write `w_q[cnt] <= in_w` and increment `cnt`. After the write with `cnt=L-1`, go to READY. Cycles with `inst_w[0]=0` are gaps: no write, no state change.
  - READY: weights frozen. `reload=1` goes to IDLE; weight registers are kept but are overwritten on the next load. `reload` is ignored in IDLE and LOAD.
- `a_q <= in_w` whenever `inst_w[0] | inst_w[1]`; otherwise `a_q` holds.
- `c_q <= in_n` every cycle.
- `inst_q[1] <= inst_w[1]` every cycle.
- `inst_q[0] <= inst_w[0]` only while the state is READY. In IDLE and LOAD, `inst_q[0] <= 0`. The first L load cycles are therefore consumed locally, and later ones pass east.
- Arithmetic: `out_s = c_q + Σ_{i<L} (act_i × w_q[i])`.
  - Products are signed.
  - The sum is computed at `psum_bw+3` bits before the final width reduction (see Configuration).
  - Lanes ≥ L contribute 0.
- `out_e = a_q`, `inst_e = inst_q`.

## Timing
- Reset: every register is cleared on the reset cycle, including in-progress loads.
  - `inst_q`, `a_q`, `c_q`, `cnt`, all `w_q` and `mode_q` are 0.
  - State is IDLE.
  - Resulting outputs: `out_e=0`, `inst_e=0`, `out_s=0`.
- Latency:
  - `in_w` to `out_e`: 1 cycle.
  - `inst_w` to `inst_e`: 1 cycle.
  - `in_n` to `out_s`: 1 cycle. `out_s` is valid in the cycle after the operand is captured.
- Simultaneous `reload=1` and `inst_w[0]=1` in READY:
  - The state goes to IDLE.
  - `inst_q[0]` takes `inst_w[0]`, because the state was READY in that cycle.
  - That weight is not captured.
- A `mode` change outside IDLE is ignored until the tile is back in IDLE.
- Asserting `inst_w[1]` during LOAD is legal. `out_s` uses the partially loaded weights. The controller must not rely on that result.

## Configuration
- `MAC_TILE_SAT_EN` defined:
  - The `psum_bw+3`-bit sum is clamped to the signed range [−2^(psum_bw−1), 2^(psum_bw−1)−1].
- Not defined:
  - The sum is truncated to the low `psum_bw` bits (two's-complement wrap).
- The macro has no other effect.

## Test plan
- Mode 0: load `w=4'hD` (−3), then execute `a=4'h5` with `in_n=10`. Required: `out_s=16'hFFFB` (−5) one cycle after capture, and `inst_e[0]` low for the load cycle.
- Mode 1: load `w0=2`, `w1=4'hF` (−1), execute `a=4'b1011`. The lanes are 3 and 2. With `in_n=0`, required `out_s=4`.
- Mode 2: load weights 1, 2, 3, −4, execute `a=4'b1011`, `in_n=0`. Required `out_s=16'hFFFF` (−1).
- Forwarding in mode 1: drive 5 load cycles with a gap after the first. Required:
  - `inst_e[0]` stays 0 for the first 2 load cycles and the gap.
  - `inst_e[0]` is 1 for each of the last 3 load cycles, one cycle later each.
  - `out_e` equals each `in_w` delayed by one cycle.
- Reload and reset:
  - `reload` in READY, then new weights: the new weights are used and the old `inst_e[0]` forwarding stops until READY again.
  - `reset` after 1 of 2 mode-1 loads: all outputs are 0, and the next load starts at lane 0.
- Overflow, `in_n=16'h7FFF`, mode 0, `w=7`, `a=1`:
  - With `MAC_TILE_SAT_EN`: `out_s=16'h7FFF`.
  - Without: `out_s=16'h8006`.
